// File: rtl/mult_fu.sv
// Pipelined integer multiply unit: NUM_STAGE shift-and-add stages, each consuming one
// chunk of the multiplier, with a global stall when the last stage waits for the CDB.
module mult_fu #(
  parameter int XLEN          = 32,
  parameter int PRN_WIDTH     = 6,
  parameter int ROB_CNT_WIDTH = 5,
  parameter int NUM_STAGE     = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [1:0]               in_func,
  input  logic [XLEN-1:0]          in_op1,
  input  logic [XLEN-1:0]          in_op2,
  input  logic [PRN_WIDTH-1:0]     in_dest_prn,
  input  logic [ROB_CNT_WIDTH-1:0] in_dest_rob,
  input  logic                     squash,
  input  logic                     cdb_grant,
  output logic                     avail,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_value,
  output logic [PRN_WIDTH-1:0]     out_dest_prn,
  output logic [ROB_CNT_WIDTH-1:0] out_dest_rob
);

  localparam int W2   = 2 * XLEN;
  localparam int CH   = W2 / NUM_STAGE;
  localparam int LAST = NUM_STAGE - 1;

  logic                     valid_q  [NUM_STAGE];
  logic [1:0]               func_q   [NUM_STAGE];
  logic [PRN_WIDTH-1:0]     prn_q    [NUM_STAGE];
  logic [ROB_CNT_WIDTH-1:0] rob_q    [NUM_STAGE];
  logic [W2-1:0]            mcand_q  [NUM_STAGE];
  logic [W2-1:0]            mplier_q [NUM_STAGE];
  logic [W2-1:0]            psum_q   [NUM_STAGE];

  logic                     src_valid  [NUM_STAGE];
  logic [1:0]               src_func   [NUM_STAGE];
  logic [PRN_WIDTH-1:0]     src_prn    [NUM_STAGE];
  logic [ROB_CNT_WIDTH-1:0] src_rob    [NUM_STAGE];
  logic [W2-1:0]            src_mcand  [NUM_STAGE];
  logic [W2-1:0]            src_mplier [NUM_STAGE];
  logic [W2-1:0]            src_psum   [NUM_STAGE];

  logic [W2-1:0]            mcand_d  [NUM_STAGE];
  logic [W2-1:0]            mplier_d [NUM_STAGE];
  logic [W2-1:0]            psum_d   [NUM_STAGE];

  logic          stall;
  logic          op1_signed;
  logic          op2_signed;
  logic [W2-1:0] issue_mcand;
  logic [W2-1:0] issue_mplier;

  assign stall = valid_q[LAST] & ~cdb_grant;
  assign avail = ~stall;

  // op1 is signed for MULH/MULHSU, op2 only for MULH
  assign op1_signed   = (in_func == 2'd1) || (in_func == 2'd2);
  assign op2_signed   = (in_func == 2'd1);
  assign issue_mcand  = {{XLEN{op1_signed & in_op1[XLEN-1]}}, in_op1};
  assign issue_mplier = {{XLEN{op2_signed & in_op2[XLEN-1]}}, in_op2};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign src_valid[gi]  = in_valid;
        assign src_func[gi]   = in_func;
        assign src_prn[gi]    = in_dest_prn;
        assign src_rob[gi]    = in_dest_rob;
        assign src_mcand[gi]  = issue_mcand;
        assign src_mplier[gi] = issue_mplier;
        assign src_psum[gi]   = '0;
      end else begin : g_rest
        assign src_valid[gi]  = valid_q[gi-1];
        assign src_func[gi]   = func_q[gi-1];
        assign src_prn[gi]    = prn_q[gi-1];
        assign src_rob[gi]    = rob_q[gi-1];
        assign src_mcand[gi]  = mcand_q[gi-1];
        assign src_mplier[gi] = mplier_q[gi-1];
        assign src_psum[gi]   = psum_q[gi-1];
      end

      // One chunk of the multiplier per stage; everything wraps at 2*XLEN bits
      assign psum_d[gi]   = src_psum[gi] + src_mcand[gi] * W2'(src_mplier[gi][CH-1:0]);
      assign mcand_d[gi]  = src_mcand[gi] << CH;
      assign mplier_d[gi] = src_mplier[gi] >> CH;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        valid_q[i]  <= 1'b0;
        func_q[i]   <= '0;
        prn_q[i]    <= '0;
        rob_q[i]    <= '0;
        mcand_q[i]  <= '0;
        mplier_q[i] <= '0;
        psum_q[i]   <= '0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        valid_q[i]  <= src_valid[i];
        func_q[i]   <= src_func[i];
        prn_q[i]    <= src_prn[i];
        rob_q[i]    <= src_rob[i];
        mcand_q[i]  <= mcand_d[i];
        mplier_q[i] <= mplier_d[i];
        psum_q[i]   <= psum_d[i];
      end
    end
  end

  assign out_valid    = valid_q[LAST];
  assign out_value    = (func_q[LAST] == 2'd0) ? psum_q[LAST][XLEN-1:0] : psum_q[LAST][W2-1:XLEN];
  assign out_dest_prn = prn_q[LAST];
  assign out_dest_rob = rob_q[LAST];

endmodule

// File: tb/tb_mult_fu.sv
// Directed-vector bench for mult_fu: latency, signed variants, throughput, stall,
// squash and asynchronous reset behaviour, each scenario in its own task.
module tb_mult_fu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_func = 2'd0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [5:0]  in_dest_prn = '0;
  logic [4:0]  in_dest_rob = '0;
  logic        squash = 1'b0;
  logic        cdb_grant = 1'b1;
  logic        avail;
  logic        out_valid;
  logic [31:0] out_value;
  logic [5:0]  out_dest_prn;
  logic [4:0]  out_dest_rob;

  int passed = 0;
  int total  = 0;

  mult_fu #(.XLEN(32), .PRN_WIDTH(6), .ROB_CNT_WIDTH(5), .NUM_STAGE(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_func(in_func),
    .in_op1(in_op1), .in_op2(in_op2), .in_dest_prn(in_dest_prn), .in_dest_rob(in_dest_rob),
    .squash(squash), .cdb_grant(cdb_grant), .avail(avail), .out_valid(out_valid),
    .out_value(out_value), .out_dest_prn(out_dest_prn), .out_dest_rob(out_dest_rob)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] p, input logic [4:0] r);
    in_valid = 1'b1; in_func = f; in_op1 = a; in_op2 = b; in_dest_prn = p; in_dest_rob = r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_value !== 32'd0) $display("FAIL reset_value: got %h expected 0", out_value); else passed++;
    total++; if (avail !== 1'b1) $display("FAIL reset_avail: got %b expected 1", avail); else passed++;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mul_basic();
    int n;
    cdb_grant = 1'b1;
    @(negedge clock); drive(2'd0, 32'd3, 32'd5, 6'd7, 5'd2);
    @(negedge clock); idle();
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin @(negedge clock); n++; end
    total++; if (n !== 4) $display("FAIL mul_latency: got %0d cycles expected 4", n); else passed++;
    total++; if (out_value !== 32'd15) $display("FAIL mul_value: got %h expected %h", out_value, 32'd15); else passed++;
    total++; if (out_dest_prn !== 6'd7) $display("FAIL mul_prn: got %0d expected 7", out_dest_prn); else passed++;
    total++; if (out_dest_rob !== 5'd2) $display("FAIL mul_rob: got %0d expected 2", out_dest_rob); else passed++;
    $display("MUL 3*5 -> %0d after %0d cycles prn=%0d rob=%0d", out_value, n, out_dest_prn, out_dest_rob);
    @(negedge clock);
    total++; if (out_valid !== 1'b0) $display("FAIL mul_drop: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_mulh();
    cdb_grant = 1'b1;
    @(negedge clock); drive(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd1, 5'd1);
    @(negedge clock); drive(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2, 5'd2);
    @(negedge clock); drive(2'd2, 32'hFFFFFFFF, 32'd2, 6'd3, 5'd3);
    @(negedge clock); idle();
    @(negedge clock);
    total++; if (out_valid !== 1'b1 || out_value !== 32'h0) $display("FAIL mulh: got v=%b %h expected v=1 00000000", out_valid, out_value); else passed++;
    $display("MULH -1*-1 -> %h", out_value);
    @(negedge clock);
    total++; if (out_valid !== 1'b1 || out_value !== 32'hFFFFFFFE) $display("FAIL mulhu: got v=%b %h expected v=1 fffffffe", out_valid, out_value); else passed++;
    $display("MULHU ffffffff*ffffffff -> %h", out_value);
    @(negedge clock);
    total++; if (out_valid !== 1'b1 || out_value !== 32'hFFFFFFFF) $display("FAIL mulhsu: got v=%b %h expected v=1 ffffffff", out_valid, out_value); else passed++;
    total++; if (out_dest_prn !== 6'd3) $display("FAIL mulhsu_prn: got %0d expected 3", out_dest_prn); else passed++;
    $display("MULHSU -1*2 -> %h", out_value);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    cdb_grant = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      total++; if (avail !== 1'b1) $display("FAIL b2b_issue_avail%0d: got %b expected 1", i, avail); else passed++;
      drive(2'd0, 32'(i), 32'(i), 6'(i), 5'(i));
    end
    @(negedge clock); idle();
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clock);
      exp_v = 32'(i * i);
      total++; if (out_valid !== 1'b1 || out_value !== exp_v) $display("FAIL b2b_result%0d: got v=%b %0d expected v=1 %0d", i, out_valid, out_value, exp_v); else passed++;
      total++; if (avail !== 1'b1) $display("FAIL b2b_avail%0d: got %b expected 1", i, avail); else passed++;
      $display("B2B %0d*%0d -> %0d", i, i, out_value);
    end
    @(negedge clock);
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_drop: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_stall();
    logic [31:0] exp_v;
    cdb_grant = 1'b0;
    @(negedge clock); drive(2'd0, 32'd6, 32'd7, 6'd9, 5'd9);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock); drive(2'd0, 32'd2, 32'(i), 6'(i), 5'(i));
    end
    @(negedge clock); drive(2'd0, 32'd2, 32'd4, 6'd4, 5'd4);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      total++; if (out_valid !== 1'b1 || out_value !== 32'd42) $display("FAIL stall_hold%0d: got v=%b %0d expected v=1 42", k, out_valid, out_value); else passed++;
      total++; if (avail !== 1'b0) $display("FAIL stall_avail%0d: got %b expected 0", k, avail); else passed++;
      $display("STALL cycle %0d value=%0d avail=%b", k, out_value, avail);
    end
    cdb_grant = 1'b1;
    @(negedge clock); idle();
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) @(negedge clock);
      exp_v = 32'(2 * i);
      total++; if (out_valid !== 1'b1 || out_value !== exp_v) $display("FAIL stall_drain%0d: got v=%b %0d expected v=1 %0d", i, out_valid, out_value, exp_v); else passed++;
      $display("DRAIN %0d -> %0d", i, out_value);
    end
    @(negedge clock);
    total++; if (out_valid !== 1'b0) $display("FAIL stall_empty: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_squash();
    int n;
    cdb_grant = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock); drive(2'd0, 32'(i + 10), 32'd1, 6'(i), 5'(i));
    end
    @(negedge clock); squash = 1'b1; drive(2'd0, 32'd100, 32'd100, 6'd8, 5'd8);
    @(negedge clock); squash = 1'b0; idle();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clock);
      total++; if (out_valid !== 1'b0) $display("FAIL squash_empty%0d: got %b expected 0", k, out_valid); else passed++;
    end
    $display("SQUASH pipeline empty for 5 cycles");
    @(negedge clock); drive(2'd0, 32'd9, 32'd9, 6'd3, 5'd3);
    @(negedge clock); idle();
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin @(negedge clock); n++; end
    total++; if (n !== 4 || out_value !== 32'd81) $display("FAIL squash_after: got %0d after %0d cycles expected 81 after 4", out_value, n); else passed++;
    $display("POST-SQUASH 9*9 -> %0d", out_value);
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    cdb_grant = 1'b0;
    @(negedge clock); drive(2'd0, 32'd5, 32'd5, 6'd4, 5'd4);
    @(negedge clock); drive(2'd0, 32'd3, 32'd3, 6'd5, 5'd5);
    @(negedge clock); idle();
    @(negedge clock);
    @(negedge clock);
    total++; if (out_valid !== 1'b1 || out_value !== 32'd25) $display("FAIL rst_pre: got v=%b %0d expected v=1 25", out_valid, out_value); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", out_valid); else passed++;
    total++; if (out_value !== 32'd0) $display("FAIL rst_value: got %0d expected 0", out_value); else passed++;
    total++; if (out_dest_prn !== 6'd0 || out_dest_rob !== 5'd0) $display("FAIL rst_tags: got %0d/%0d expected 0/0", out_dest_prn, out_dest_rob); else passed++;
    total++; if (avail !== 1'b1) $display("FAIL rst_avail: got %b expected 1", avail); else passed++;
    $display("MID-OP RESET outputs cleared");
    @(negedge clock); reset = 1'b1; cdb_grant = 1'b1; drive(2'd0, 32'd7, 32'd8, 6'd6, 5'd6);
    @(negedge clock); idle();
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clock);
      total++; if (out_valid !== (k == 4)) $display("FAIL rst_after_valid%0d: got %b expected %b", k, out_valid, (k == 4)); else passed++;
      if (k == 4) begin
        total++; if (out_value !== 32'd56) $display("FAIL rst_after_value: got %0d expected 56", out_value); else passed++;
        $display("POST-RESET 7*8 -> %0d", out_value);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mulh();
    test_back_to_back();
    test_stall();
    test_squash();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
MULT_FU -- requirements
Module: mult_fu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter PRN_WIDTH, default 6, physical register tag width.
REQ-003 SHALL have parameter ROB_CNT_WIDTH, default 5, ROB index width.
REQ-004 SHALL have parameter NUM_STAGE, default 4, pipeline depth; 2*XLEN divisible by NUM_STAGE.
REQ-005 SHALL have port clock  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 SHALL have port in_valid  input  1  issue request from RS mult port.
REQ-008 SHALL have port in_func  input  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
REQ-009 SHALL have port in_op1 / in_op2  input  XLEN each  rs1 / rs2 values.
REQ-010 SHALL have port in_dest_prn  input  PRN_WIDTH  destination tag.
REQ-011 SHALL have port in_dest_rob  input  ROB_CNT_WIDTH  ROB index.
REQ-012 SHALL have port squash  input  1  flush all in-flight ops.
REQ-013 SHALL have port cdb_grant  input  1  CDB arbiter accepts current output.
REQ-014 SHALL have port avail  output  1  drives RS fu_mult_avail; issue may be accepted.
REQ-015 SHALL have port out_valid  output  1  result ready for CDB.
REQ-016 SHALL have port out_value  output  XLEN  result.
REQ-017 SHALL have port out_dest_prn / out_dest_rob  output  PRN_WIDTH / ROB_CNT_WIDTH  tags of result.

Function
REQ-018 SHALL hold NUM_STAGE stage registers S1..SN, each: valid, func, dest_prn, dest_rob, multiplicand (2*XLEN), remaining multiplier (2*XLEN), partial sum (2*XLEN).
REQ-019 SHALL, at issue, extend op1 to 2*XLEN signed for MULH/MULHSU else zero-extended; op2 signed-extended for MULH only, else zero-extended.
REQ-020 SHALL in each stage add (multiplicand * low 2*XLEN/NUM_STAGE bits of multiplier) to partial sum, then shift multiplicand left and multiplier right by that chunk width; all arithmetic modulo 2^(2*XLEN).
REQ-021 SHALL output low XLEN product bits for MUL, high XLEN bits for MULH/MULHSU/MULHU.
REQ-022 SHALL define stall = SN.valid & ~cdb_grant; avail = ~stall (combinational).
REQ-023 SHALL capture issue into S1 at a rising edge only when in_valid & avail; in_valid while ~avail is ignored (RS holds it).
REQ-024 SHALL advance all stages one step per edge when ~stall; when stall, all stage registers hold.
REQ-025 SHALL give latency exactly NUM_STAGE edges: op accepted at edge t appears with out_valid=1 in the cycle after edge t+NUM_STAGE-1 (no stall).
REQ-026 SHALL sustain throughput of one op per cycle with cdb_grant held high.
REQ-027 SHALL drive out_valid = SN.valid and out_* from SN; out_value stable while stalled.
REQ-028 SHALL, when SN.valid & cdb_grant and no new op reaches SN, drop out_valid next cycle.
REQ-029 SHALL, on squash at an edge, clear every stage valid and ignore same-edge in_valid; squash dominates cdb_grant.
REQ-030 SHALL treat cdb_grant with out_valid=0 as no-op.

Reset
REQ-031 SHALL on reset=0 immediately clear all stage valid bits, out_valid=0, out_value=0, out_dest_prn=0, out_dest_rob=0, avail=1, independent of clock.
REQ-032 SHALL discard in-flight ops when reset asserts mid-operation; no result emerges after release.
REQ-033 SHALL accept a new issue at the first rising edge after reset deasserts.

Verification
REQ-034 MUL op1=3 op2=5 prn=7 rob=2, cdb_grant=1 -> out_valid=1 after 4 edges, out_value=15, prn 7, rob 2, single cycle.
REQ-035 MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same -> 0xFFFFFFFE; MULHSU op1=0xFFFFFFFF op2=2 -> 0xFFFFFFFF.
REQ-036 Four back-to-back MULs (1*1,2*2,3*3,4*4), grant high -> results 1,4,9,16 on four consecutive cycles, avail stays 1.
REQ-037 Grant low with result 42 at output, keep issuing -> avail=0, out_value holds 42, no op lost; grant high -> remaining results in order.
REQ-038 Three ops in flight then squash -> out_valid stays 0 for next 5 cycles; op issued after squash returns correctly.
REQ-039 Reset asserted between edges with two ops in flight -> outputs 0 and avail=1 immediately; no stale result after release.
